// File: rtl/pmp_step_aligner.sv
// N-step fringe-frame aligner: round-robins input frames into per-lane buffers and emits one wide beat per aligned group.
// Optional tlast length check enabled by defining PMP_ALIGN_LEN_CHECK_EN.
module pmp_step_aligner #(
  parameter int unsigned NUM_STEPS   = 4,
  parameter int unsigned BEAT_WIDTH  = 128,
  parameter int unsigned FRAME_DEPTH = 256
) (
  input  logic                            aclk,
  input  logic                            areset,
  input  logic [3:0]                      cfg_steps,
  input  logic [BEAT_WIDTH-1:0]           s_axis_tdata,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  input  logic                            s_axis_tlast,
  output logic [NUM_STEPS*BEAT_WIDTH-1:0] m_axis_tdata,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic                            m_axis_tlast,
  output logic [3:0]                      active_steps,
  output logic [15:0]                     group_cnt,
  output logic                            len_err,
  output logic                            len_err_sticky
);

  localparam int unsigned PTR_W  = $clog2(FRAME_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned SEL_W  = $clog2(NUM_STEPS);
  localparam int unsigned STEP_W = 4;
  localparam int unsigned ENT_W  = BEAT_WIDTH + 1;

  logic [1:0]                      rst_sync;
  logic [ENT_W-1:0]                mem [NUM_STEPS][FRAME_DEPTH];
  logic [PTR_W-1:0]                wptr [NUM_STEPS];
  logic [PTR_W-1:0]                rptr [NUM_STEPS];
  logic [CNT_W-1:0]                cnt  [NUM_STEPS];
  logic [SEL_W-1:0]                wsel;
  logic [SEL_W-1:0]                last_sel;
  logic                            in_frame;
  logic [NUM_STEPS-1:0]            full;
  logic [NUM_STEPS-1:0]            nonempty;
  logic [NUM_STEPS-1:0]            lane_act;
  logic [NUM_STEPS-1:0]            push_lane;
  logic [NUM_STEPS-1:0]            pop_lane;
  logic [NUM_STEPS*BEAT_WIDTH-1:0] pop_data;
  logic [STEP_W-1:0]               cfg_clamped;
  logic                            push;
  logic                            pop;
  logic                            all_ready;
  logic                            cfg_load;

  // Reset is applied asynchronously but released on a clock edge before accepting input
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) rst_sync <= 2'b11;
    else        rst_sync <= {rst_sync[0], 1'b0};
  end

  // Per-lane status and the concatenated head-of-buffer beat
  always_comb begin
    full      = '0;
    nonempty  = '0;
    lane_act  = '0;
    push_lane = '0;
    pop_lane  = '0;
    pop_data  = '0;
    for (int k = 0; k < NUM_STEPS; k++) begin
      full[k]     = (cnt[k] == CNT_W'(FRAME_DEPTH));
      nonempty[k] = (cnt[k] != '0);
      lane_act[k] = (STEP_W'(k) < active_steps);
      if (lane_act[k]) pop_data[k*BEAT_WIDTH +: BEAT_WIDTH] = mem[k][rptr[k]][BEAT_WIDTH-1:0];
    end
    all_ready = &(nonempty | ~lane_act);
    push      = s_axis_tvalid & s_axis_tready;
    pop       = all_ready & (~m_axis_tvalid | m_axis_tready);
    for (int k = 0; k < NUM_STEPS; k++) begin
      push_lane[k] = push & (wsel == SEL_W'(k));
      pop_lane[k]  = pop & lane_act[k];
    end
    cfg_clamped = (cfg_steps < 4'd2 || cfg_steps > STEP_W'(NUM_STEPS)) ? STEP_W'(NUM_STEPS) : cfg_steps;
    cfg_load    = (wsel == '0) & ~in_frame & ~|nonempty;
    last_sel    = SEL_W'(active_steps - 4'd1);
  end

  assign s_axis_tready = ~full[wsel] & ~rst_sync[1];

  always_ff @(posedge aclk) begin
    if (push) mem[wsel][wptr[wsel]] <= {s_axis_tlast, s_axis_tdata};
  end

  // Ring pointers and occupancy per lane
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      for (int k = 0; k < NUM_STEPS; k++) begin
        wptr[k] <= '0;
        rptr[k] <= '0;
        cnt[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_STEPS; k++) begin
        if (push_lane[k]) wptr[k] <= wptr[k] + PTR_W'(1);
        if (pop_lane[k])  rptr[k] <= rptr[k] + PTR_W'(1);
        case ({push_lane[k], pop_lane[k]})
          2'b10:   cnt[k] <= cnt[k] + CNT_W'(1);
          2'b01:   cnt[k] <= cnt[k] - CNT_W'(1);
          default: cnt[k] <= cnt[k];
        endcase
      end
    end
  end

  // Write selector, step-count latch and output register
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wsel          <= '0;
      in_frame      <= 1'b0;
      active_steps  <= STEP_W'(NUM_STEPS);
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
      group_cnt     <= '0;
    end else begin
      if (push) begin
        in_frame <= ~s_axis_tlast;
        if (s_axis_tlast) wsel <= (wsel == last_sel) ? '0 : wsel + SEL_W'(1);
      end
      if (cfg_load) active_steps <= cfg_clamped;
      if (pop) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= pop_data;
        m_axis_tlast  <= mem[0][rptr[0]][BEAT_WIDTH];
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
      if (m_axis_tvalid && m_axis_tready && m_axis_tlast) group_cnt <= group_cnt + 16'd1;
    end
  end

`ifdef PMP_ALIGN_LEN_CHECK_EN
  logic tl_mismatch;

  // Active lanes must agree on tlast at every popped position
  always_comb begin
    tl_mismatch = 1'b0;
    for (int k = 0; k < NUM_STEPS; k++) begin
      if (lane_act[k] && (mem[k][rptr[k]][BEAT_WIDTH] != mem[0][rptr[0]][BEAT_WIDTH])) tl_mismatch = 1'b1;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      len_err        <= 1'b0;
      len_err_sticky <= 1'b0;
    end else begin
      len_err <= pop & tl_mismatch;
      if (pop && tl_mismatch) len_err_sticky <= 1'b1;
    end
  end
`else
  assign len_err        = 1'b0;
  assign len_err_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_pmp_step_aligner.sv
// Randomised and directed bench for pmp_step_aligner against a lane-queue reference model.
module tb_pmp_step_aligner;
  localparam int NS = 4;
  localparam int BW = 32;
  localparam int FD = 16;
  localparam int OW = NS * BW;

  logic          aclk = 1'b0;
  logic          areset;
  logic [3:0]    cfg_steps;
  logic [BW-1:0] s_tdata;
  logic          s_tvalid, s_tready, s_tlast;
  logic [OW-1:0] m_tdata;
  logic          m_tvalid, m_tready, m_tlast;
  logic [3:0]    active_steps;
  logic [15:0]   group_cnt;
  logic          len_err, len_err_sticky;

  pmp_step_aligner #(.NUM_STEPS(NS), .BEAT_WIDTH(BW), .FRAME_DEPTH(FD)) dut (
    .aclk(aclk), .areset(areset), .cfg_steps(cfg_steps),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tlast(s_tlast),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tlast(m_tlast),
    .active_steps(active_steps), .group_cnt(group_cnt), .len_err(len_err), .len_err_sticky(len_err_sticky)
  );

  always #5 aclk = ~aclk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [OW:0] act, input logic [OW:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_total++;
    $display("FAIL %s", name);
  endtask

  // Reference model: each lane is a plain array of {tlast,data} with read/write indices
  logic [BW:0]  mlane [NS][1024];
  int           wr_i [NS];
  int           rd_i [NS];
  int           m_wsel, m_active, m_gc, exp_err, dut_err;
  logic [OW:0]  exp_q [$];
  logic [OW:0]  obs [256];
  int           obs_n;
  logic [OW:0]  prev_out;
  bit           prev_stall;
  bit           rand_ready;

  task automatic model_clear();
    for (int k = 0; k < NS; k++) begin
      wr_i[k] = 0;
      rd_i[k] = 0;
    end
    exp_q.delete();
    m_wsel = 0; m_gc = 0; m_active = NS; exp_err = 0; dut_err = 0;
  endtask

  task automatic model_push(input logic [BW-1:0] d, input logic tl);
    bit          ok;
    bit          mis;
    logic [BW:0] e;
    logic        tl0;
    logic [OW-1:0] beat;
    mlane[m_wsel][wr_i[m_wsel]] = {tl, d};
    wr_i[m_wsel]++;
    if (tl) m_wsel = (m_wsel + 1) % m_active;
    forever begin
      ok = 1'b1;
      for (int k = 0; k < m_active; k++) if (rd_i[k] >= wr_i[k]) ok = 1'b0;
      if (!ok) break;
      beat = '0;
      mis  = 1'b0;
      tl0  = mlane[0][rd_i[0]][BW];
      for (int k = 0; k < m_active; k++) begin
        e = mlane[k][rd_i[k]];
        rd_i[k]++;
        beat[k*BW +: BW] = e[BW-1:0];
        if (e[BW] != tl0) mis = 1'b1;
      end
      exp_q.push_back({tl0, beat});
`ifdef PMP_ALIGN_LEN_CHECK_EN
      if (mis) exp_err++;
`endif
    end
  endtask

  // Monitor and compare, sampled mid-cycle away from the active edge
  always @(negedge aclk) begin
    logic [OW:0] e;
    if (areset) begin
      prev_stall = 1'b0;
    end else begin
      if (m_tvalid) begin
        if (prev_stall) chk("hold_stable", {m_tlast, m_tdata}, prev_out);
        if (m_tready) begin
          if (exp_q.size() == 0) fail_now("unexpected_output_beat");
          else begin
            e = exp_q.pop_front();
            chk("out_beat", {m_tlast, m_tdata}, e);
          end
          chk("group_cnt", (OW+1)'(group_cnt), (OW+1)'(m_gc));
          if (m_tlast) m_gc = (m_gc + 1) & 32'hffff;
          if (obs_n < 256) begin
            obs[obs_n] = {m_tlast, m_tdata};
            obs_n++;
          end
        end
      end
      prev_stall = m_tvalid & ~m_tready;
      prev_out   = {m_tlast, m_tdata};
      if (len_err) dut_err++;
      if (s_tvalid && s_tready) model_push(s_tdata, s_tlast);
    end
  end

  always @(posedge aclk) begin
    #1;
    if (rand_ready) m_tready = 1'($urandom_range(0, 1));
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic send_frame(input int len, input int base, input bit gaps);
    bit acc;
    int tmo;
    for (int i = 0; i < len; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        s_tvalid = 1'b0;
        cycles(1);
      end
      s_tdata  = BW'(base + i);
      s_tlast  = (i == len - 1);
      s_tvalid = 1'b1;
      tmo = 0;
      acc = 1'b0;
      while (!acc && tmo < 2000) begin
        @(negedge aclk);
        acc = s_tready;
        @(posedge aclk);
        #1;
        tmo++;
      end
      if (!acc) begin
        fail_now("send_timeout");
        s_tvalid = 1'b0;
        return;
      end
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic wait_drain();
    int tmo = 0;
    while ((exp_q.size() != 0 || m_tvalid) && tmo < 2000) begin
      cycles(1);
      tmo++;
    end
    if (tmo >= 2000) fail_now("drain_timeout");
    cycles(2);
  endtask

  task automatic do_reset();
    areset = 1'b1;
    #2;
    chk("rst_tvalid", (OW+1)'(m_tvalid), '0);
    chk("rst_tready_low", (OW+1)'(s_tready), '0);
    model_clear();
    cycles(1);
    areset = 1'b0;
    cycles(3);
    chk("post_rst_tready", (OW+1)'(s_tready), (OW+1)'(1));
    chk("post_rst_group_cnt", (OW+1)'(group_cnt), '0);
    chk("post_rst_active", (OW+1)'(active_steps), (OW+1)'(4));
    chk("post_rst_sticky", (OW+1)'(len_err_sticky), '0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog_expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int len;
    int exp_pulse;
    areset = 1'b1; cfg_steps = 4'd4; s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0;
    m_tready = 1'b1; rand_ready = 1'b0; obs_n = 0; prev_stall = 1'b0;
    model_clear();
    @(negedge aclk);
    chk("reset_tvalid", (OW+1)'(m_tvalid), '0);
    chk("reset_tdata", (OW+1)'(m_tdata), '0);
    chk("reset_tready", (OW+1)'(s_tready), '0);
    chk("reset_active", (OW+1)'(active_steps), (OW+1)'(4));
    chk("reset_group_cnt", (OW+1)'(group_cnt), '0);
    chk("reset_len_err", (OW+1)'({len_err, len_err_sticky}), '0);
    cycles(2);
    areset = 1'b0;
    cycles(3);
    chk("release_tready", (OW+1)'(s_tready), (OW+1)'(1));

    // Four 8-beat frames, full step count
    obs_n = 0;
    for (int k = 0; k < 4; k++) send_frame(8, k * 256, 1'b0);
    wait_drain();
    chk("t1_beats", (OW+1)'(obs_n), (OW+1)'(8));
    chk("t1_beat0", obs[0], {1'b0, 32'd768, 32'd512, 32'd256, 32'd0});
    chk("t1_beat7", obs[7], {1'b1, 32'd775, 32'd519, 32'd263, 32'd7});
    chk("t1_group_cnt", (OW+1)'(group_cnt), (OW+1)'(1));
    chk("t1_no_len_err", (OW+1)'(dut_err), '0);

    // Three active steps, two groups to show the selector wrapping to lane 0
    cfg_steps = 4'd3;
    cycles(3);
    chk("t2_active", (OW+1)'(active_steps), (OW+1)'(3));
    m_active = 3;
    obs_n = 0;
    for (int g = 0; g < 2; g++)
      for (int k = 0; k < 3; k++) send_frame(4, g * 4096 + k * 256, 1'b0);
    wait_drain();
    chk("t2_beats", (OW+1)'(obs_n), (OW+1)'(8));
    chk("t2_beat0", obs[0], {1'b0, 32'd0, 32'd512, 32'd256, 32'd0});
    chk("t2_beat3", obs[3], {1'b1, 32'd0, 32'd515, 32'd259, 32'd3});
    chk("t2_beat4", obs[4], {1'b0, 32'd0, 32'd4608, 32'd4352, 32'd4096});

    // Step count change requested after the group has started
    cfg_steps = 4'd4;
    cycles(3);
    m_active = 4;
    chk("t3_active4", (OW+1)'(active_steps), (OW+1)'(4));
    rand_ready = 1'b1;
    send_frame(5, 32'h100, 1'b1);
    cfg_steps = 4'd2;
    cycles(2);
    chk("t3_hold_mid_group", (OW+1)'(active_steps), (OW+1)'(4));
    for (int k = 1; k < 4; k++) send_frame(5, 32'h100 + k * 256, 1'b1);
    wait_drain();
    cycles(3);
    chk("t3_active2", (OW+1)'(active_steps), (OW+1)'(2));
    m_active = 2;
    for (int k = 0; k < 4; k++) send_frame(3, int'($urandom_range(0, 32'h7fff_0000)), 1'b1);
    wait_drain();
    rand_ready = 1'b0;
    m_tready = 1'b1;

    // Fill lane 0 to depth while the output is stalled
    cfg_steps = 4'd4;
    cycles(3);
    m_active = 4;
    m_tready = 1'b0;
    for (int k = 0; k < 4; k++) send_frame(FD, 32'h10000 + k * 256, 1'b0);
    fork
      send_frame(FD, 32'h20000, 1'b0);
      begin
        cycles(20);
        chk("t4_full_tready", (OW+1)'(s_tready), '0);
        chk("t4_stalled_valid", (OW+1)'(m_tvalid), (OW+1)'(1));
        m_tready = 1'b1;
      end
    join
    for (int k = 1; k < 4; k++) send_frame(FD, 32'h20000 + k * 256, 1'b0);
    wait_drain();

    // Frame lengths 8,8,7,8
    for (int k = 0; k < 4; k++) send_frame((k == 2) ? 7 : 8, 32'h30000 + k * 256, 1'b0);
    wait_drain();
    cycles(4);
`ifdef PMP_ALIGN_LEN_CHECK_EN
    exp_pulse = 1;
`else
    exp_pulse = 0;
`endif
    chk("t5_err_vs_model", (OW+1)'(dut_err), (OW+1)'(exp_err));
    chk("t5_err_pulses", (OW+1)'(dut_err), (OW+1)'(exp_pulse));
    chk("t5_sticky", (OW+1)'(len_err_sticky), (OW+1)'(exp_pulse));
    do_reset();

    // Reset in the middle of a held group
    m_tready = 1'b0;
    for (int k = 0; k < 4; k++) send_frame(4, 32'h40000 + k * 256, 1'b0);
    send_frame(2, 32'h41000, 1'b0);
    chk("t6_pre_valid", (OW+1)'(m_tvalid), (OW+1)'(1));
    do_reset();
    m_tready = 1'b1;
    obs_n = 0;
    for (int k = 0; k < 4; k++) send_frame(4, 32'h300 + k * 256, 1'b0);
    wait_drain();
    chk("t6_realigned", obs[0], {1'b0, 32'h600, 32'h500, 32'h400, 32'h300});

    // Random traffic with random back-pressure at 4 and 2 steps
    rand_ready = 1'b1;
    for (int g = 0; g < 6; g++) begin
      len = $urandom_range(1, 6);
      for (int k = 0; k < 4; k++) send_frame(len, int'($urandom_range(0, 32'h7fff_0000)), 1'b1);
    end
    wait_drain();
    cfg_steps = 4'd2;
    cycles(3);
    chk("t7_active2", (OW+1)'(active_steps), (OW+1)'(2));
    m_active = 2;
    for (int g = 0; g < 4; g++) begin
      len = $urandom_range(1, 6);
      for (int k = 0; k < 2; k++) send_frame(len, int'($urandom_range(0, 32'h7fff_0000)), 1'b1);
    end
    wait_drain();
    rand_ready = 1'b0;
    m_tready = 1'b1;
    cfg_steps = 4'd9;
    cycles(3);
    chk("clamp_high", (OW+1)'(active_steps), (OW+1)'(4));
    cfg_steps = 4'd1;
    cycles(3);
    chk("clamp_low", (OW+1)'(active_steps), (OW+1)'(4));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/pmp_step_aligner.md
# pmp_step_aligner

Parametrised N-step fringe-frame aligner for the PMP role, the generalised successor of the fixed 4-step pixel buffering in front of the relative-phase core. It accepts phase-shifted camera frames back-to-back on one AXI-Stream slave and distributes them round-robin into NUM_STEPS per-lane frame buffers. Once every active lane holds data, it emits one wide beat carrying beat i of every frame in the group. It sits between the frame DMA stream and any N-step phase/modulation calculator. The active step count is runtime-selectable, and it adds frame-length mismatch detection.

## Interface
- NUM_STEPS, 4: physical lane count; legal 2..8.
- BEAT_WIDTH, 128: bits per input beat.
- FRAME_DEPTH, 256: beats per lane buffer; power of 2.
- aclk  in  1  clock.
- areset  in  1  asynchronous, active-high reset.
- cfg_steps  in  4  requested active step count; values <2 or >NUM_STEPS are clamped to NUM_STEPS.
- s_axis_tdata  in  BEAT_WIDTH  fringe pixels.
- s_axis_tvalid  in  1
- s_axis_tready  out  1
- s_axis_tlast  in  1  last beat of a frame.
- m_axis_tdata  out  NUM_STEPS*BEAT_WIDTH  lane k occupies bits [k*BEAT_WIDTH +: BEAT_WIDTH].
- m_axis_tvalid  out  1
- m_axis_tready  in  1
- m_axis_tlast  out  1  lane-0 tlast.
- active_steps  out  4  latched step count.
- group_cnt  out  16  completed output groups, wraps at 65535->0.
- len_err  out  1  one-cycle pulse on a lane tlast mismatch.
- len_err_sticky  out  1  held until reset.

## Operation
- Write selector `wsel` (0..active_steps-1):
  - Each accepted input beat is written to lane `wsel`.
  - An accepted beat with tlast advances `wsel`, wrapping to 0 after active_steps-1.
- s_axis_tready = !full[wsel]. A lane is full when its count equals FRAME_DEPTH.
- Each lane is a circular buffer holding {tlast, tdata}:
  - log2(FRAME_DEPTH)-bit read and write pointers.
  - log2(FRAME_DEPTH)+1-bit occupancy count.
  - Simultaneous push and pop leaves the count unchanged.
- Pop condition: all lanes < active_steps are non-empty AND (!m_axis_tvalid | m_axis_tready).
  - On pop, all active lanes advance their read pointers together.
  - The output register loads the concatenated beat.
- Lanes >= active_steps output zero data and are never popped.
- active_steps loads from clamped cfg_steps only when all three hold: wsel==0, no frame partially written (`in_frame`==0), and all lanes empty. Otherwise it holds its value.
- Length check: on pop, compare the tlast bits of all active lanes.
  - If they are not all equal, len_err pulses in the cycle after the pop and len_err_sticky is set.
  - Data is still forwarded unchanged.
- group_cnt increments on each m_axis handshake with m_axis_tlast=1.

## Timing
- Reset (async assert, sync-released internally):
  - m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0.
  - s_axis_tready=1 after release; it reads 0 while areset is high.
  - wsel=0, all pointers and counts 0.
  - active_steps=NUM_STEPS, group_cnt=0, len_err=0, len_err_sticky=0.
- Latency:
  - A beat accepted at edge t into the last-filled lane can be popped at edge t+1.
  - m_axis_tvalid is high from t+1, so latency is 1 cycle after the enabling write.
- Throughput: one output beat per cycle while all active lanes are non-empty and m_axis_tready=1.
- m_axis_tdata/tlast stay stable while m_axis_tvalid=1 and m_axis_tready=0.
- A write into a full lane is impossible, because tready is 0.
- A pop from an empty lane is impossible, because the pop condition gates it.
- Reset mid-frame discards all buffered data and returns wsel to 0.

## Configuration
- PMP_ALIGN_LEN_CHECK_EN defined: tlast comparison, len_err and len_err_sticky are implemented as above.
- Not defined:
  - The comparison logic is absent.
  - len_err and len_err_sticky are tied to 0.
  - All other behaviour is identical.

## Test plan
- NUM_STEPS=4, cfg_steps=4, four 8-beat frames (frame k, beat i data = k*256+i), m_axis_tready=1:
  - Required: 8 output beats, beat i lanes = {3*256+i, 2*256+i, 256+i, i}.
  - m_axis_tlast only on the 8th beat; group_cnt=1; len_err never asserted.
- cfg_steps=3 with buffers empty, then three 4-beat frames:
  - Required: active_steps=3, lane 3 data=0, 4 output beats, wsel wraps 2->0.
- Change cfg_steps from 4 to 2 mid-frame:
  - Required: active_steps stays 4 until the current group drains and wsel==0, then becomes 2.
- FRAME_DEPTH=16 with m_axis_tready=0, stream 16 beats into lane 0:
  - Required: s_axis_tready drops after the 16th accept; no beat lost after tready returns.
- Frame lengths 8,8,7,8 with the check enabled:
  - Required: len_err pulses once on the mismatching pop; sticky=1 until areset.
  - With the macro off: both flags stay 0.
- Assert areset for 1 cycle mid-group:
  - Required: m_axis_tvalid=0 immediately, counts 0, the next full group aligns from lane 0.
